// File: rtl/ws_input_skewer.sv
// ws_input_skewer: input feeder for the weight-stationary systolic array.
// Accepts one ROWS-wide vector of signed activations per cycle and skews it so
// lane r reaches the array r cycles after lane 0. After the last vector of a
// tile it drains zeros until every partial sum has left the array.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   weight_load   array is loading weights; aborts the tile and clears all lanes
//   in_valid/in_ready/in_data/in_last   vector input handshake
//   skew_data     lane r drives data_in of array row r
//   skew_valid    lane r carries a real accepted element
//   busy          controller is not idle
//   drain_done    single-cycle pulse on the final drain cycle
module ws_input_skewer #(
  parameter int unsigned ROWS          = 4,
  parameter int unsigned COLS          = 4,
  parameter int unsigned DATA_IN_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          weight_load,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROWS*DATA_IN_WIDTH-1:0] in_data,
  input  logic                          in_last,
  output logic [ROWS*DATA_IN_WIDTH-1:0] skew_data,
  output logic [ROWS-1:0]               skew_valid,
  output logic                          busy,
  output logic                          drain_done
);

  localparam int unsigned W         = DATA_IN_WIDTH;
  localparam int unsigned CNT_W     = $clog2(ROWS + COLS) + 1;
  localparam int unsigned DRAIN_LEN = ROWS - 1 + COLS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;

  // Handshake, status and next-state logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_ready   = !rst && !weight_load && (state_q != DRAIN);
    accept     = in_valid && in_ready;
    busy       = (state_q != IDLE);
    // Suppressed under reset and weight_load so an aborted tile never reports completion.
    drain_done = !rst && !weight_load && (state_q == DRAIN) && (cnt_q == CNT_W'(1));

    if (weight_load) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, STREAM: begin
          if (accept) begin
            if (in_last) begin
              state_d = DRAIN;
              cnt_d   = CNT_W'(DRAIN_LEN);
            end else begin
              state_d = STREAM;
            end
          end
        end
        DRAIN: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Controller registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Per-lane delay line: lane r is r+1 free-running stages deep.
  for (genvar r = 0; r < int'(ROWS); r++) begin : g_lane
    localparam int unsigned DEPTH = r + 1;

    logic [W-1:0]     dat_q [DEPTH];
    logic [W-1:0]     dat_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;

    // Bubbles always carry zero data so they contribute nothing to the sums.
    always_comb begin
      vld_d = '0;
      for (int i = 0; i < int'(DEPTH); i++) dat_d[i] = '0;
      if (!weight_load) begin
        vld_d[0] = accept;
        dat_d[0] = accept ? in_data[r*W +: W] : '0;
        for (int i = 1; i < int'(DEPTH); i++) begin
          dat_d[i] = dat_q[i-1];
          vld_d[i] = vld_q[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
        for (int i = 0; i < int'(DEPTH); i++) dat_q[i] <= '0;
      end else begin
        vld_q <= vld_d;
        for (int i = 0; i < int'(DEPTH); i++) dat_q[i] <= dat_d[i];
      end
    end

    assign skew_data[r*W +: W] = dat_q[DEPTH-1];
    assign skew_valid[r]       = vld_q[DEPTH-1];
  end

endmodule
